// File: rtl/aq_cp0_fflags_arb.sv
// Accrued fflags arbiter: merges FPU/VPU retire flags into CSR update pulses behind the FS-dirty handshake.
// Define AQ_FFLAGS_ARB_VPU_EN to let the VPU retire port contribute flags; otherwise only the FPU does.
module aq_cp0_fflags_arb (
   input  logic       forever_cpuclk,
   input  logic       cpurst_b,
   input  logic       fpu_fflags_vld,
   input  logic [4:0] fpu_fflags,
   input  logic       vpu_fflags_vld,
   input  logic [4:0] vpu_fflags,
   input  logic       fs_is_dirty,
   input  logic       fs_dirty_ack,
   input  logic       iui_fcsr_acc_req,
   output logic [4:0] arb_cp0_fflags,
   output logic       arb_cp0_fflags_updt,
   output logic       arb_fs_dirty_req,
   output logic       arb_iui_fcsr_acc_gnt,
   output logic       arb_fs_dirty_upd_gate
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DIRTY_WAIT = 2'd1,
      UPDT       = 2'd2
   } state_t;

   state_t     state_reg;
   logic [4:0] pend_reg;
   logic [4:0] fflags_reg;
   logic       updt_reg;
   logic       dirty_req_reg;
   logic [4:0] fpu_in;
   logic [4:0] vpu_in;
   logic [4:0] in_flags;
   logic [4:0] pend_acc;

   assign fpu_in = fpu_fflags_vld ? fpu_fflags : 5'd0;

`ifdef AQ_FFLAGS_ARB_VPU_EN
   assign vpu_in = vpu_fflags_vld ? vpu_fflags : 5'd0;
`else
   // Ports stay so both builds instantiate identically; their values are dropped here.
   logic unused_vpu;
   assign unused_vpu = vpu_fflags_vld ^ (^vpu_fflags);
   assign vpu_in     = 5'd0;
`endif

   assign in_flags = fpu_in | vpu_in;

   // Flags arriving in the UPDT cycle are not in this strobe; they start the next round.
   assign pend_acc = ((state_reg == UPDT) ? 5'd0 : pend_reg) | in_flags;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_reg     <= IDLE;
         pend_reg      <= 5'd0;
         fflags_reg    <= 5'd0;
         updt_reg      <= 1'b0;
         dirty_req_reg <= 1'b0;
      end else begin
         pend_reg      <= pend_acc;
         fflags_reg    <= 5'd0;
         updt_reg      <= 1'b0;
         dirty_req_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (pend_reg != 5'd0) begin
                  if (fs_is_dirty) begin
                     state_reg  <= UPDT;
                     updt_reg   <= 1'b1;
                     fflags_reg <= pend_acc;
                  end else begin
                     state_reg     <= DIRTY_WAIT;
                     dirty_req_reg <= 1'b1;
                  end
               end
            end
            DIRTY_WAIT: begin
               if (fs_dirty_ack) begin
                  state_reg  <= UPDT;
                  updt_reg   <= 1'b1;
                  fflags_reg <= pend_acc;
               end else begin
                  dirty_req_reg <= 1'b1;
               end
            end
            UPDT: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign arb_cp0_fflags      = fflags_reg;
   assign arb_cp0_fflags_updt = updt_reg;
   assign arb_fs_dirty_req    = dirty_req_reg;

   // Combinational outputs are forced low while reset is held so every output reads 0 in reset.
   assign arb_iui_fcsr_acc_gnt  = cpurst_b & iui_fcsr_acc_req & (state_reg == IDLE)
                                & (pend_reg == 5'd0) & (in_flags == 5'd0);
   assign arb_fs_dirty_upd_gate = cpurst_b & ((state_reg != IDLE) | (pend_reg != 5'd0)
                                | (in_flags != 5'd0));

endmodule
